text_buf_writer: RTL and testbench

//  Writer side of the on-screen text path. Accepts a stream of 7-bit ASCII codes

---
 rtl/text_buf_writer_if.sv | 28 ++
 rtl/text_buf_writer.sv | 138 +++++++++++++
 tb/tb_text_buf_writer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_buf_writer_if.sv
// rtl/text_buf_writer_if.sv - code stream, clear request and RAM write bundle of the text buffer writer
interface text_buf_writer_if #(
   parameter int COLS_LOG2 = 5,
   parameter int ROWS_LOG2 = 2
);
   logic                           ch_valid;
   logic [6:0]                     ch_data;
   logic                           ch_ready;
   logic                           clr_req;
   logic                           busy;
   logic                           wr_en;
   logic [COLS_LOG2+ROWS_LOG2-1:0] wr_addr;
   logic [6:0]                     wr_data;
   logic [COLS_LOG2-1:0]           cur_col;
   logic [ROWS_LOG2-1:0]           cur_row;

   // Character source side: supplies codes and clear requests, observes the writer.
   modport master (
      output ch_valid, ch_data, clr_req,
      input  ch_ready, busy, wr_en, wr_addr, wr_data, cur_col, cur_row
   );

   // Writer side: consumes codes and drives the character RAM write port.
   modport slave (
      input  ch_valid, ch_data, clr_req,
      output ch_ready, busy, wr_en, wr_addr, wr_data, cur_col, cur_row
   );
endinterface

// File: rtl/text_buf_writer.sv
// rtl/text_buf_writer.sv - writes an ASCII code stream into the character RAM at a tracked cursor
module text_buf_writer #(
   parameter int COLS_LOG2 = 5,
   parameter int ROWS_LOG2 = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   text_buf_writer_if.slave bus
);
   localparam int AW = COLS_LOG2 + ROWS_LOG2;
   localparam logic [AW-1:0]        LAST_IDX = '1;
   localparam logic [COLS_LOG2-1:0] LAST_COL = '1;

   localparam logic [6:0] C_BS = 7'h08;
   localparam logic [6:0] C_LF = 7'h0A;
   localparam logic [6:0] C_FF = 7'h0C;
   localparam logic [6:0] C_CR = 7'h0D;

   typedef enum logic {S_CLEAR, S_IDLE} state_t;

   state_t               state_q;
   logic [AW-1:0]        idx_q;
   logic [COLS_LOG2-1:0] col_q;
   logic [ROWS_LOG2-1:0] row_q;
   // ready_q is low through the last sweep-write cycle so that busy and
   // acceptance change together one cycle after the final clear write.
   logic                 ready_q;
   logic                 busy_q;
   logic                 wr_en_q;
   logic [AW-1:0]        wr_addr_q;
   logic [6:0]           wr_data_q;

   logic                 take;
   logic                 is_print;
   logic [COLS_LOG2-1:0] adv_col_d;
   logic [ROWS_LOG2-1:0] adv_row_d;
   logic [COLS_LOG2-1:0] bs_col_d;

   // A pending clear request pre-empts the code offered in the same cycle.
   assign take     = bus.ch_valid && ready_q && !bus.clr_req;
   assign is_print = (bus.ch_data >= 7'h20) && (bus.ch_data <= 7'h7E);

   // Cursor candidates: advance with row wrap (rows wrap by width), and backspace column.
   always_comb begin
      adv_col_d = col_q + 1'b1;
      adv_row_d = row_q;
      if (col_q == LAST_COL) begin
         adv_row_d = row_q + 1'b1;
      end
      bs_col_d = col_q - 1'b1;
   end

   // Control FSM: clear sweep, then code handling with registered write outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_CLEAR;
         idx_q     <= '0;
         col_q     <= '0;
         row_q     <= '0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b1;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         case (state_q)
            S_CLEAR: begin
               wr_en_q   <= 1'b1;
               wr_addr_q <= idx_q;
               wr_data_q <= 7'h00;
               idx_q     <= idx_q + 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_q <= S_IDLE;
                  col_q   <= '0;
                  row_q   <= '0;
               end
            end
            S_IDLE: begin
               wr_en_q <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
               if (ready_q && bus.clr_req) begin
                  state_q <= S_CLEAR;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
               end else if (take) begin
                  if (is_print) begin
                     wr_en_q   <= 1'b1;
                     wr_addr_q <= {row_q, col_q};
                     wr_data_q <= bus.ch_data;
                     col_q     <= adv_col_d;
                     row_q     <= adv_row_d;
                  end else begin
                     case (bus.ch_data)
                        C_CR: begin
                           col_q <= '0;
                        end
                        C_LF: begin
                           col_q <= '0;
                           row_q <= row_q + 1'b1;
                        end
                        C_BS: begin
                           if (col_q != '0) begin
                              col_q     <= bs_col_d;
                              wr_en_q   <= 1'b1;
                              wr_addr_q <= {row_q, bs_col_d};
                              wr_data_q <= 7'h00;
                           end
                        end
                        C_FF: begin
                           state_q <= S_CLEAR;
                           idx_q   <= '0;
                           busy_q  <= 1'b1;
                           ready_q <= 1'b0;
                        end
                        default: begin
                        end
                     endcase
                  end
               end
            end
            default: begin
               state_q <= S_CLEAR;
               idx_q   <= '0;
            end
         endcase
      end
   end

   assign bus.ch_ready = ready_q && !bus.clr_req;
   assign bus.busy     = busy_q;
   assign bus.wr_en    = wr_en_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.cur_col  = col_q;
   assign bus.cur_row  = row_q;
endmodule

// File: tb/tb_text_buf_writer.sv
// tb/tb_text_buf_writer.sv - self-checking bench for text_buf_writer
module tb_text_buf_writer;
   localparam int CL    = 5;
   localparam int RL    = 2;
   localparam int COLS  = 32;
   localparam int ROWS  = 4;
   localparam int CELLS = 128;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   text_buf_writer_if #(.COLS_LOG2(CL), .ROWS_LOG2(RL)) bus ();

   text_buf_writer #(.COLS_LOG2(CL), .ROWS_LOG2(RL)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: m_p counts cycles since a clear began (busy while <= CELLS).
   int m_p;
   int m_col;
   int m_row;
   bit m_we;
   int m_wa;
   int m_wd;
   int m_scr [CELLS];
   int d_scr [CELLS];

   function automatic void chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endfunction

   task automatic model_code(input int c);
      int pos;
      if (c >= 32 && c <= 126) begin
         pos  = m_row * COLS + m_col;
         m_we = 1'b1;
         m_wa = pos;
         m_wd = c;
         pos  = (pos + 1) % CELLS;
         m_row = pos / COLS;
         m_col = pos % COLS;
      end else if (c == 13) begin
         m_col = 0;
      end else if (c == 10) begin
         m_col = 0;
         m_row = (m_row + 1) % ROWS;
      end else if (c == 8) begin
         if (m_col > 0) begin
            m_col = m_col - 1;
            m_we  = 1'b1;
            m_wa  = m_row * COLS + m_col;
            m_wd  = 0;
         end
      end else if (c == 12) begin
         m_p = 0;
      end
   endtask

   // Model update on every active edge / reset.
   initial begin
      m_p = 0; m_col = 0; m_row = 0; m_we = 1'b0; m_wa = 0; m_wd = 0;
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            m_p = 0; m_col = 0; m_row = 0; m_we = 1'b0; m_wa = 0; m_wd = 0;
         end else begin
            if (m_p <= CELLS) begin
               m_p = m_p + 1;
               if (m_p == CELLS) begin
                  m_col = 0;
                  m_row = 0;
               end
               m_we = (m_p <= CELLS);
               m_wa = m_p - 1;
               m_wd = 0;
            end else begin
               m_we = 1'b0;
               if (bus.clr_req) m_p = 0;
               else if (bus.ch_valid) model_code(int'(bus.ch_data));
            end
            if (m_we) m_scr[m_wa] = m_wd;
         end
      end
   end

   // Cycle compare against the model on the falling edge.
   initial begin
      bit ok;
      bit e_busy;
      bit e_ready;
      forever begin
         @(negedge clk);
         e_busy  = (m_p <= CELLS);
         e_ready = (m_p > CELLS) && !bus.clr_req;
         ok = (bus.busy == e_busy) && (bus.ch_ready == e_ready) && (bus.wr_en == m_we) &&
              (int'(bus.cur_col) == m_col) && (int'(bus.cur_row) == m_row) &&
              (!m_we || (int'(bus.wr_addr) == m_wa && int'(bus.wr_data) == m_wd));
         n_cmp++;
         if (!ok) begin
            n_bad++;
            $display("FAIL cycle_model t=%0t: got busy=%0b rdy=%0b we=%0b a=%0h d=%0h col=%0d row=%0d expected busy=%0b rdy=%0b we=%0b a=%0h d=%0h col=%0d row=%0d",
                     $time, bus.busy, bus.ch_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.cur_col, bus.cur_row,
                     e_busy, e_ready, m_we, m_wa, m_wd, m_col, m_row);
         end
         if (bus.wr_en) d_scr[int'(bus.wr_addr)] = int'(bus.wr_data);
      end
   end

   task automatic send(input logic [6:0] c);
      int n;
      n = 0;
      bus.ch_valid = 1'b1;
      bus.ch_data  = c;
      @(negedge clk);
      while (!bus.ch_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) chk("send_timeout", n, 0);
      @(posedge clk);
      #2;
      bus.ch_valid = 1'b0;
   endtask

   task automatic wait_sweep(input string nm);
      int  n_wr;
      int  k;
      bit  seq_ok;
      n_wr = 0; k = 0; seq_ok = 1'b1;
      while (k < 400) begin
         @(posedge clk);
         #2;
         k++;
         if (bus.wr_en) begin
            if (int'(bus.wr_addr) != n_wr || bus.wr_data != 7'h00 || !bus.busy) seq_ok = 1'b0;
            n_wr++;
         end
         if (!bus.busy) break;
      end
      chk({nm, "_writes"}, n_wr, CELLS);
      chk({nm, "_addr_seq"}, int'(seq_ok), 1);
      chk({nm, "_busy_low"}, int'(bus.busy), 0);
      chk({nm, "_ready"}, int'(bus.ch_ready), 1);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_busy"}, int'(bus.busy), 1);
      chk({nm, "_ready"}, int'(bus.ch_ready), 0);
      chk({nm, "_wr_en"}, int'(bus.wr_en), 0);
      chk({nm, "_wr_addr"}, int'(bus.wr_addr), 0);
      chk({nm, "_wr_data"}, int'(bus.wr_data), 0);
      chk({nm, "_col"}, int'(bus.cur_col), 0);
      chk({nm, "_row"}, int'(bus.cur_row), 0);
   endtask

   task automatic chk_wr(input string nm, input int we, input int a, input int d);
      chk({nm, "_wr_en"}, int'(bus.wr_en), we);
      if (we != 0) begin
         chk({nm, "_wr_addr"}, int'(bus.wr_addr), a);
         chk({nm, "_wr_data"}, int'(bus.wr_data), d);
      end
   endtask

   task automatic chk_cur(input string nm, input int col, input int row);
      chk({nm, "_col"}, int'(bus.cur_col), col);
      chk({nm, "_row"}, int'(bus.cur_row), row);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int diff;
      int r;
      bus.ch_valid = 1'b0;
      bus.ch_data  = 7'h00;
      bus.clr_req  = 1'b0;
      reset_n      = 1'b0;

      // Reset state and the initial sweep.
      #12;
      chk_reset_vals("reset");
      @(posedge clk); #2;
      reset_n = 1'b1;
      wait_sweep("sweep0");

      // Two printable codes, one-cycle write latency.
      send(7'h42);
      chk_wr("B", 1, 8'h00, 8'h42);
      send(7'h75);
      chk_wr("u", 1, 8'h01, 8'h75);
      chk_cur("after_Bu", 2, 0);

      // Column wrap into the next row, then full wrap to home.
      for (int i = 0; i < 29; i++) send(7'(8'h61 + (i % 26)));
      chk_cur("at_31_0", 31, 0);
      send(7'h78);
      chk_wr("x", 1, 8'h1F, 8'h78);
      chk_cur("wrap_row", 0, 1);
      send(7'h0A);
      send(7'h0A);
      for (int i = 0; i < 31; i++) send(7'h2E);
      chk_cur("at_31_3", 31, 3);
      send(7'h71);
      chk_wr("last_cell", 1, 8'h7F, 8'h71);
      chk_cur("wrap_home", 0, 0);

      // Backspace over a character, then backspace at column 0.
      send(7'h61);
      chk_wr("a", 1, 8'h00, 8'h61);
      send(7'h08);
      chk_wr("bs1", 1, 8'h00, 8'h00);
      chk_cur("bs1", 0, 0);
      send(7'h08);
      chk_wr("bs2", 0, 0, 0);
      chk_cur("bs2", 0, 0);

      // CR, LF and an unhandled control code.
      send(7'h0A);
      send(7'h0A);
      for (int i = 0; i < 5; i++) send(7'h30);
      chk_cur("at_5_2", 5, 2);
      send(7'h0D);
      chk_wr("cr", 0, 0, 0);
      chk_cur("cr", 0, 2);
      send(7'h0A);
      chk_wr("lf", 0, 0, 0);
      chk_cur("lf", 0, 3);
      send(7'h01);
      chk_wr("soh", 0, 0, 0);
      chk_cur("soh", 0, 3);

      // clr_req beats a simultaneous code; the code is accepted after the sweep.
      bus.clr_req  = 1'b1;
      bus.ch_valid = 1'b1;
      bus.ch_data  = 7'h7A;
      #1;
      chk("clr_vs_valid_ready", int'(bus.ch_ready), 0);
      @(posedge clk); #2;
      bus.clr_req = 1'b0;
      chk("clr_busy", int'(bus.busy), 1);
      send(7'h7A);
      chk_wr("z_after_clr", 1, 8'h00, 8'h7A);
      chk_cur("z_after_clr", 1, 0);

      // Reset in the middle of a sweep.
      bus.clr_req = 1'b1;
      @(posedge clk); #2;
      bus.clr_req = 1'b0;
      repeat (40) @(posedge clk);
      #3;
      chk("mid_sweep_busy", int'(bus.busy), 1);
      reset_n = 1'b0;
      #1;
      chk_reset_vals("mid_reset");
      @(posedge clk); #2;
      reset_n = 1'b1;
      wait_sweep("sweep_rst");

      // Randomised traffic checked cycle by cycle against the model.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bus.ch_valid = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 15);
         if ($urandom_range(0, 399) == 0)      bus.ch_data = 7'h0C;
         else if (r < 11)                      bus.ch_data = 7'($urandom_range(32, 126));
         else if (r == 11)                     bus.ch_data = 7'h0D;
         else if (r == 12)                     bus.ch_data = 7'h0A;
         else if (r == 13)                     bus.ch_data = 7'h08;
         else                                  bus.ch_data = 7'($urandom_range(0, 127));
         bus.clr_req = ($urandom_range(0, 499) == 0);
         @(posedge clk); #2;
      end
      bus.ch_valid = 1'b0;
      bus.clr_req  = 1'b0;
      repeat (140) @(posedge clk);
      #2;

      // Buffer contents written by the DUT against the model's screen.
      diff = 0;
      for (int i = 0; i < CELLS; i++) if (m_scr[i] != d_scr[i]) diff++;
      chk("screen_cells_differ", diff, 0);

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
